// File: rtl/vending_pkg.sv
// Shared types and display constants for the multi-slot vending controller.
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VEND  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_e;

    // Hex digit to segments, bit order gfedcba; element [15] is listed first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_FAULT = 7'b1001001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vending_ctrl_multi_if.sv
// Pin-side bundle of the vending controller: keypad, drop sensors, relays and status.
interface vending_ctrl_multi_if #(
    parameter int COLS  = 3,
    parameter int ROWS  = 3,
    parameter int NSENS = 2
);
    logic [COLS-1:0]      coluna_in;
    logic [ROWS-1:0]      linha_in;
    logic [NSENS-1:0]     sensor_in;
    logic [COLS*ROWS-1:0] rele_out;
    logic [6:0]           seg_out;
    logic                 busy_out;
    logic                 fault_out;

    modport master (
        output coluna_in, linha_in, sensor_in,
        input  rele_out, seg_out, busy_out, fault_out
    );

    modport slave (
        input  coluna_in, linha_in, sensor_in,
        output rele_out, seg_out, busy_out, fault_out
    );
endinterface

// File: rtl/vending_keydec.sv
// Keypad decoder: one-hot column/row to slot index, with a consecutive-sample debouncer.
module vending_keydec
    import vending_pkg::*;
#(
    parameter int COLS         = 3,
    parameter int ROWS         = 3,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            sens_ok_i,
    input  logic [COLS-1:0] col_i,
    input  logic [ROWS-1:0] row_i,
    output logic [3:0]      slot_o,
    output logic            accept_o
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC) + 1;

    logic            valid;
    logic [3:0]      col_idx;
    logic [3:0]      row_idx;
    logic [3:0]      slot;
    logic [3:0]      last_q, last_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Slot arithmetic is modulo 16; COLS*ROWS <= 16 keeps it exact.
    always_comb begin
        col_idx = '0;
        row_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (col_i[i]) col_idx = 4'(i);
        end
        for (int j = 0; j < ROWS; j++) begin
            if (row_i[j]) row_idx = 4'(j);
        end
        valid = $onehot(col_i) && $onehot(row_i);
        slot  = row_idx * 4'(COLS) + col_idx;
    end

    always_comb begin
        last_d = valid ? slot : last_q;
        cnt_d  = '0;
        if (en_i && valid && sens_ok_i) begin
            if (cnt_q != '0 && slot == last_q) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = {{(DB_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign slot_o   = slot;
    assign accept_o = (cnt_d == DB_W'(DEBOUNCE_CYC));

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-slot vending controller: debounced selection, timed relay attempts with retry,
// filtered drop confirmation, latched fault and 7-segment status.
module vending_ctrl_multi
    import vending_pkg::*;
#(
    parameter int COLS         = 3,
    parameter int ROWS         = 3,
    parameter int NSENS        = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SENSOR_FILT  = 4,
    parameter int VEND_TIMEOUT = 3000,
    parameter int PAUSE_CYC    = 500,
    parameter int MAX_RETRY    = 2,
    parameter int DONE_CYC     = 100
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    vending_ctrl_multi_if.slave  bus
);
    localparam int NSLOT  = COLS * ROWS;
    localparam int CYC_W  = $clog2(max3(VEND_TIMEOUT, PAUSE_CYC, DONE_CYC)) + 1;
    localparam int FILT_W = $clog2(SENSOR_FILT) + 1;
    localparam int ATT_W  = $clog2(MAX_RETRY) + 1;

    state_e             state_q, state_d;
    logic [3:0]         slot_q, slot_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d, cyc_inc;
    logic [FILT_W-1:0]  filt_q, filt_d, filt_inc;
    logic [NSLOT-1:0]   rele_q, rele_d;
    logic [6:0]         seg_q, seg_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;

    logic               key_accept;
    logic [3:0]         key_slot;
    logic               sens_ok;
    logic               keys_clear;
    logic               in_vend_or_pause;
    logic               drop;

    assign sens_ok          = &bus.sensor_in;
    assign keys_clear       = (bus.coluna_in == '0) && (bus.linha_in == '0);
    assign in_vend_or_pause = (state_q == VEND) || (state_q == PAUSE);

    vending_keydec #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_keydec (
        .clk_i     (clock_in),
        .rst_i     (reset_in),
        .en_i      (state_q == IDLE),
        .sens_ok_i (sens_ok),
        .col_i     (bus.coluna_in),
        .row_i     (bus.linha_in),
        .slot_o    (key_slot),
        .accept_o  (key_accept)
    );

    always_comb begin
        cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        filt_inc = (filt_q == '1) ? filt_q : filt_q + 1'b1;
        drop     = in_vend_or_pause && !sens_ok && (filt_inc >= FILT_W'(SENSOR_FILT));
    end

    // Next state; a confirmed drop is checked before any timer expiry.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        att_d   = att_q;
        cyc_d   = '0;
        filt_d  = (in_vend_or_pause && !sens_ok) ? filt_inc : '0;

        unique case (state_q)
            IDLE: begin
                if (key_accept) begin
                    state_d = VEND;
                    slot_d  = key_slot;
                    att_d   = '0;
                end
            end
            VEND: begin
                cyc_d = cyc_inc;
                if (drop) begin
                    state_d = DONE;
                    cyc_d   = '0;
                end else if (cyc_inc >= CYC_W'(VEND_TIMEOUT)) begin
                    cyc_d = '0;
                    if (att_q < ATT_W'(MAX_RETRY)) begin
                        state_d = PAUSE;
                        att_d   = att_q + 1'b1;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            PAUSE: begin
                cyc_d = cyc_inc;
                if (drop) begin
                    state_d = DONE;
                    cyc_d   = '0;
                end else if (cyc_inc >= CYC_W'(PAUSE_CYC)) begin
                    state_d = VEND;
                    cyc_d   = '0;
                    filt_d  = '0;
                end
            end
            DONE: begin
                cyc_d = cyc_inc;
                if (cyc_inc >= CYC_W'(DONE_CYC) && keys_clear && sens_ok) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they change on the same edge.
    always_comb begin
        rele_d  = '0;
        seg_d   = SEG_DASH;
        busy_d  = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            VEND: begin
                rele_d = {{(NSLOT-1){1'b0}}, 1'b1} << slot_d;
                seg_d  = HEX_SEG[slot_d];
                busy_d = 1'b1;
            end
            PAUSE, DONE: begin
                seg_d  = HEX_SEG[slot_d];
                busy_d = 1'b1;
            end
            FAULT: begin
                seg_d   = SEG_FAULT;
                fault_d = 1'b1;
            end
            default: begin
                seg_d = SEG_DASH;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            slot_q  <= '0;
            att_q   <= '0;
            cyc_q   <= '0;
            filt_q  <= '0;
            rele_q  <= '0;
            seg_q   <= SEG_DASH;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            att_q   <= att_d;
            cyc_q   <= cyc_d;
            filt_q  <= filt_d;
            rele_q  <= rele_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign bus.rele_out  = rele_q;
    assign bus.seg_out   = seg_q;
    assign bus.busy_out  = busy_q;
    assign bus.fault_out = fault_q;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Directed bench for vending_ctrl_multi: a 3x3 instance and a 4x4 instance on one clock.
module tb_vending_ctrl_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    vending_ctrl_multi_if #(.COLS(3), .ROWS(3), .NSENS(2)) bus_a ();
    vending_ctrl_multi_if #(.COLS(4), .ROWS(4), .NSENS(2)) bus_b ();

    vending_ctrl_multi dut_a (
        .clock_in (clk),
        .reset_in (rst_a),
        .bus      (bus_a)
    );

    vending_ctrl_multi #(.COLS(4), .ROWS(4)) dut_b (
        .clock_in (clk),
        .reset_in (rst_b),
        .bus      (bus_b)
    );

    int n_chk = 0;
    int n_bad = 0;

    int hl[3];
    int ll[2];
    int run, hi_idx, lo_idx, fault_at;
    logic prev_r, cur_r, seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic keys_a(input logic [2:0] c, input logic [2:0] r);
        bus_a.coluna_in = c;
        bus_a.linha_in  = r;
    endtask

    // Holds a key for the debounce window, then releases it.
    task automatic press_a(input logic [2:0] c, input logic [2:0] r);
        keys_a(c, r);
        cyc(16);
        keys_a(3'b000, 3'b000);
    endtask

    task automatic finish_a(input string tag);
        bus_a.sensor_in = 2'b00;
        cyc(4);
        bus_a.sensor_in = 2'b11;
        cyc(100);
        check(tag, {31'd0, bus_a.busy_out}, 32'd0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        keys_a(3'b000, 3'b000);
        bus_a.sensor_in = 2'b11;
        bus_b.coluna_in = 4'b0000;
        bus_b.linha_in  = 4'b0000;
        bus_b.sensor_in = 2'b11;
        cyc(2);
        rst_a = 1'b0;
        rst_b = 1'b0;

        check("rst_rele",  {23'd0, bus_a.rele_out}, 32'd0);
        check("rst_seg",   {25'd0, bus_a.seg_out}, 32'h40);
        check("rst_busy",  {31'd0, bus_a.busy_out}, 32'd0);
        check("rst_fault", {31'd0, bus_a.fault_out}, 32'd0);

        // Slot 7 press, drop after 900 cycles, return to idle.
        keys_a(3'b010, 3'b100);
        cyc(15);
        check("s7_pre", {23'd0, bus_a.rele_out}, 32'd0);
        cyc(1);
        check("s7_rele", {23'd0, bus_a.rele_out}, 32'h080);
        check("s7_seg",  {25'd0, bus_a.seg_out}, 32'h07);
        check("s7_busy", {31'd0, bus_a.busy_out}, 32'd1);
        keys_a(3'b000, 3'b000);
        cyc(900);
        bus_a.sensor_in = 2'b00;
        cyc(3);
        check("s7_drop_pre", {23'd0, bus_a.rele_out}, 32'h080);
        cyc(1);
        check("s7_drop_rele", {23'd0, bus_a.rele_out}, 32'd0);
        check("s7_done_busy", {31'd0, bus_a.busy_out}, 32'd1);
        bus_a.sensor_in = 2'b11;
        cyc(99);
        check("s7_done_hold", {31'd0, bus_a.busy_out}, 32'd1);
        cyc(1);
        check("s7_idle_busy", {31'd0, bus_a.busy_out}, 32'd0);
        check("s7_idle_seg",  {25'd0, bus_a.seg_out}, 32'h40);

        // Bouncing key never accepted, then stable slot 5 is.
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((i % 16) < 8) keys_a(3'b001, 3'b001);
            else              keys_a(3'b100, 3'b010);
            cyc(1);
            seen = seen | (|bus_a.rele_out);
        end
        check("bounce_no_relay", {31'd0, seen}, 32'd0);
        keys_a(3'b000, 3'b000);
        cyc(1);
        keys_a(3'b100, 3'b010);
        cyc(15);
        check("s5_pre", {23'd0, bus_a.rele_out}, 32'd0);
        cyc(1);
        check("s5_rele", {23'd0, bus_a.rele_out}, 32'h020);
        check("s5_seg",  {25'd0, bus_a.seg_out}, 32'h6D);
        keys_a(3'b000, 3'b000);
        finish_a("s5_back_idle");

        // Invalid pattern, then valid key blocked by a low sensor.
        keys_a(3'b011, 3'b001);
        cyc(20);
        check("inv_rele", {23'd0, bus_a.rele_out}, 32'd0);
        check("inv_seg",  {25'd0, bus_a.seg_out}, 32'h40);
        keys_a(3'b001, 3'b001);
        bus_a.sensor_in = 2'b01;
        cyc(20);
        check("sens_block", {23'd0, bus_a.rele_out}, 32'd0);
        bus_a.sensor_in = 2'b11;
        cyc(15);
        check("sens_pre", {23'd0, bus_a.rele_out}, 32'd0);
        cyc(1);
        check("s0_rele", {23'd0, bus_a.rele_out}, 32'h001);
        check("s0_seg",  {25'd0, bus_a.seg_out}, 32'h3F);
        keys_a(3'b000, 3'b000);
        finish_a("s0_back_idle");

        // Drop confirmed on the same edge as the first timeout.
        press_a(3'b001, 3'b001);
        cyc(2996);
        bus_a.sensor_in = 2'b00;
        cyc(3);
        check("coin_pre", {23'd0, bus_a.rele_out}, 32'h001);
        cyc(1);
        check("coin_rele", {23'd0, bus_a.rele_out}, 32'd0);
        check("coin_busy", {31'd0, bus_a.busy_out}, 32'd1);
        bus_a.sensor_in = 2'b11;
        cyc(100);
        check("coin_idle", {31'd0, bus_a.busy_out}, 32'd0);

        // Late fall during the pause.
        press_a(3'b001, 3'b001);
        cyc(3000);
        check("pause_rele", {23'd0, bus_a.rele_out}, 32'd0);
        check("pause_busy", {31'd0, bus_a.busy_out}, 32'd1);
        cyc(100);
        finish_a("pause_drop_idle");
        check("pause_drop_seg", {25'd0, bus_a.seg_out}, 32'h40);

        // No drop at all: three pulses then fault.
        press_a(3'b001, 3'b001);
        run = 1; hi_idx = 0; lo_idx = 0; fault_at = -1; prev_r = 1'b1;
        for (int k = 1; k <= 10000; k++) begin
            cyc(1);
            cur_r = bus_a.rele_out[0];
            if (cur_r == prev_r) begin
                run++;
            end else begin
                if (prev_r) begin
                    if (hi_idx < 3) hl[hi_idx] = run;
                    hi_idx++;
                end else begin
                    if (lo_idx < 2) ll[lo_idx] = run;
                    lo_idx++;
                end
                run = 1;
                prev_r = cur_r;
            end
            if (fault_at < 0 && bus_a.fault_out) fault_at = k;
        end
        check("pulse_count", hi_idx, 32'd3);
        check("pulse0_len", hl[0], 32'd3000);
        check("pulse1_len", hl[1], 32'd3000);
        check("pulse2_len", hl[2], 32'd3000);
        check("gap0_len", ll[0], 32'd500);
        check("gap1_len", ll[1], 32'd500);
        check("fault_time", fault_at, 32'd10000);
        keys_a(3'b001, 3'b001);
        for (int k = 0; k < 40; k++) begin
            bus_a.sensor_in = (k % 2 == 0) ? 2'b00 : 2'b11;
            cyc(1);
        end
        keys_a(3'b000, 3'b000);
        bus_a.sensor_in = 2'b11;
        cyc(120);
        check("fault_hold", {31'd0, bus_a.fault_out}, 32'd1);
        check("fault_seg",  {25'd0, bus_a.seg_out}, 32'h49);
        check("fault_rele", {23'd0, bus_a.rele_out}, 32'd0);
        check("fault_busy", {31'd0, bus_a.busy_out}, 32'd0);
        rst_a = 1'b1;
        cyc(1);
        rst_a = 1'b0;
        check("fault_clr", {31'd0, bus_a.fault_out}, 32'd0);
        check("fault_clr_seg", {25'd0, bus_a.seg_out}, 32'h40);

        // One-cycle reset in the middle of a vend.
        press_a(3'b010, 3'b100);
        cyc(50);
        check("mid_rele_on", {23'd0, bus_a.rele_out}, 32'h080);
        rst_a = 1'b1;
        cyc(1);
        rst_a = 1'b0;
        check("mid_rst_rele",  {23'd0, bus_a.rele_out}, 32'd0);
        check("mid_rst_seg",   {25'd0, bus_a.seg_out}, 32'h40);
        check("mid_rst_busy",  {31'd0, bus_a.busy_out}, 32'd0);
        check("mid_rst_fault", {31'd0, bus_a.fault_out}, 32'd0);

        // 4x4 keypad: slot 15.
        bus_b.coluna_in = 4'b1000;
        bus_b.linha_in  = 4'b1000;
        cyc(16);
        check("b15_rele", {16'd0, bus_b.rele_out}, 32'h8000);
        check("b15_seg",  {25'd0, bus_b.seg_out}, 32'h71);
        check("b15_busy", {31'd0, bus_b.busy_out}, 32'd1);
        bus_b.coluna_in = 4'b0000;
        bus_b.linha_in  = 4'b0000;
        cyc(20);
        rst_b = 1'b1;
        cyc(1);
        rst_b = 1'b0;
        check("b_rst_rele", {16'd0, bus_b.rele_out}, 32'd0);
        check("b_rst_seg",  {25'd0, bus_b.seg_out}, 32'h40);
        check("b_rst_busy", {31'd0, bus_b.busy_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vending_ctrl_multi.md
# vending_ctrl_multi

Parametrised vending-machine controller: scans a one-hot COLS×ROWS keypad, debounces a selection, drives one relay per product slot, and confirms the drop with a filtered bank of active-low drop sensors. It is the next generation of the single-relay vending machine. It adds:
- multi-slot relays
- timeout with automatic retry
- a latched fault state
- a 7-segment status display

It sits between the keypad/sensor pins and the relay drivers.

## Interface
Parameters:
- COLS, 3, keypad columns.
- ROWS, 3, keypad rows. COLS*ROWS must be ≤ 16.
- NSENS, 2, number of drop sensors.
- DEBOUNCE_CYC, 16, consecutive stable samples needed to accept a key.
- SENSOR_FILT, 4, consecutive low samples needed to confirm a drop.
- VEND_TIMEOUT, 3000, relay-on cycles per attempt.
- PAUSE_CYC, 500, relay-off gap between attempts.
- MAX_RETRY, 2, extra attempts after the first.
- DONE_CYC, 100, minimum hold time in DONE.

Ports:
- clock_in  in  1  single clock; all logic on its rising edge.
- reset_in  in  1  synchronous, active-high reset.
- coluna_in  in  COLS  keypad column lines, one-hot when a key is pressed.
- linha_in  in  ROWS  keypad row lines, one-hot when a key is pressed.
- sensor_in  in  NSENS  drop sensors; active-low (0 = product seen).
- rele_out  out  COLS*ROWS  slot relays; at most one bit high.
- seg_out  out  7  display segments, active-high, bit order gfedcba.
- busy_out  out  1  high in VEND, PAUSE and DONE.
- fault_out  out  1  high in FAULT.

## Operation
Key decode:
- A key is valid only when exactly one coluna_in bit and exactly one linha_in bit are set.
- Slot index = row_bit_index*COLS + col_bit_index.
- Any other pattern, including all-zero, is "no key".

States:
- IDLE
  - Debounce counter counts consecutive samples with the same valid key while all sensor_in bits are 1.
  - A change of key, an invalid pattern, or any sensor low clears the counter.
  - When the count reaches DEBOUNCE_CYC, latch the slot, clear the attempt counter, and go to VEND.
- VEND
  - rele_out[slot]=1 and the cycle counter runs.
  - Drop = any sensor_in bit low for SENSOR_FILT consecutive samples. On a drop, go to DONE.
  - When the cycle counter reaches VEND_TIMEOUT: go to PAUSE if attempts < MAX_RETRY (attempts+1), otherwise go to FAULT.
  - Drop and timeout on the same edge: drop wins.
  - Keys are ignored.
- PAUSE
  - Relay off for PAUSE_CYC cycles, then return to VEND with the cycle counter and sensor filter cleared.
  - A drop confirmed in PAUSE (late fall) goes to DONE.
- DONE
  - Relay off.
  - Leave for IDLE after at least DONE_CYC cycles, and only once coluna_in = 0, linha_in = 0 and all sensors are 1.
- FAULT
  - Relay off; the state is left only by reset_in.

Display:
- IDLE: dash, 1000000.
- VEND, PAUSE, DONE: hex digit of the slot, using the standard gfedcba table.
- FAULT: 1001001 (segments a, d, g).

## Timing
- All outputs are registered and update on the same edge as the state register.
- Reset values: state IDLE, rele_out = 0, seg_out = 1000000, busy_out = 0, fault_out = 0, all counters 0.
- Key latency: VEND is entered on the DEBOUNCE_CYC-th consecutive valid sampling edge. Relay and busy_out rise on that edge.
- Drop latency: DONE is entered on the SENSOR_FILT-th consecutive low sample edge. The relay falls on that edge.
- Timeout: the relay is high for exactly VEND_TIMEOUT cycles per attempt. Worst case to FAULT is (MAX_RETRY+1)*VEND_TIMEOUT + MAX_RETRY*PAUSE_CYC cycles.
- reset_in asserted in any state: on the next edge the relay drops and all reset values are applied; reset overrides every other event.
- Counter widths are $clog2 of the largest compared value plus 1; counters saturate and never wrap.

## Structure
- Package vending_pkg holds:
  - state enum (IDLE, VEND, PAUSE, DONE, FAULT)
  - 16-entry hex-to-gfedcba table
  - DASH and FAULT segment constants
- Sub-module vending_keydec decodes coluna_in/linha_in into a valid flag and slot index, plus a valid-key debounce counter.
- The top level holds the FSM, sensor filter, timers and output registers.

## Test plan
All scenarios use default parameters unless stated.
- Reset, then coluna_in = 010, linha_in = 100 held 16 cycles:
  - VEND, rele_out = 9'b010000000 (slot 7), seg_out = 0000111, busy_out = 1.
  - After 900 cycles, sensor_in = 00 for 4 cycles: relay off, DONE.
  - After release and ≥ 100 cycles: IDLE, seg_out = 1000000.
- Key bounces (pattern toggles every 8 cycles for 64 cycles) -> relay never rises; a subsequent stable 16-cycle press is accepted.
- Invalid keys:
  - coluna_in = 011, linha_in = 001 -> ignored.
  - Valid key while sensor_in = 01 -> ignored until sensors read 11.
- No drop:
  - Relay pulses three times, 3000 cycles each, separated by 500-cycle gaps.
  - Then FAULT: fault_out = 1, seg_out = 1001001, held until reset_in.
- Drop and timeout coincide on the 3000th cycle -> DONE, not PAUSE. A drop during PAUSE -> DONE.
- reset_in pulsed 1 cycle mid-VEND -> rele_out = 0 next edge, all outputs at reset values. Repeat with COLS = 4, ROWS = 4: slot 15 drives rele_out[15], seg_out = 1110001.
